adder_bist_checker: RTL

- Synthesizable stimulus/response engine for the team's W-bit ripple-carry adders; it sits on the operand side of an adder instance and closes the loop on its outputs.
- It sweeps every {cin, a, b} combination into the adder and samples s/cout after a programmable settle time. Each result is compared against an internal golden sum.
- It reports pass/fail, a saturating error count and the first failing vector, so adder checks run on-board without a simulator.

---
 rtl/adder_bist_checker.sv | 103 ++++++++++
 1 files changed

// File: rtl/adder_bist_checker.sv
// Built-in self-test engine for a WIDTH-bit adder: sweeps every {cin, a, b} vector,
// samples s/cout after a settle delay and reports pass, error count and first failure.
module adder_bist_checker #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned INCLUDE_CIN   = 0,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic               cin,
    input  logic [WIDTH-1:0]   s,
    input  logic               cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [2*WIDTH:0]   first_fail
);

    localparam int unsigned NV = 2 * WIDTH + INCLUDE_CIN;
    localparam logic [NV-1:0] V_LAST = '1;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_t;

    state_t            state;
    logic [NV-1:0]     v;
    logic [3:0]        settle_cnt;
    logic [WIDTH:0]    golden;
    logic              mismatch;
    logic [ERR_W-1:0]  err_next;

    // Operands are plain slices of the registered vector index.
    assign b = v[WIDTH-1:0];
    assign a = v[2*WIDTH-1:WIDTH];

    if (INCLUDE_CIN != 0) begin : g_cin
        assign cin = v[NV-1];
    end else begin : g_no_cin
        assign cin = 1'b0;
    end

    assign golden   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign mismatch = ({cout, s} != golden);
    assign err_next = (mismatch && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            v          <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        v          <= '0;
                        settle_cnt <= '0;
                        err_cnt    <= '0;
                        first_fail <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        state      <= StSettle;
                    end
                end
                StSettle: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= StCheck;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                StCheck: begin
                    err_cnt <= err_next;
                    // Only the first mismatch of a sweep is recorded.
                    if (mismatch && (err_cnt == '0)) begin
                        first_fail <= {cin, a, b};
                    end
                    if (v != V_LAST) begin
                        v     <= v + 1'b1;
                        state <= StSettle;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= StDone;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
